// File: rtl/pc_unit_if.sv
// -----------------------------------------------------------------------------
// pc_unit_if
// Groups the control and status signals that connect the branch-resolution
// logic (master) to the program counter unit (slave).
//
// Signals (direction seen from the master):
//   stall        out  hold the sequential increment
//   redir_valid  out  redirect the PC to redir_target
//   redir_target out  redirect destination, WIDTH bits
//   call         out  qualifies a redirect as a call (pushes return address)
//   ret          out  return; next PC is popped from the return-address stack
//   pc           in   current fetch address, WIDTH bits
//   pc_valid     in   pc is a valid fetch address
//   ras_empty    in   return-address stack holds no entries
//   ras_full     in   return-address stack is full
//   ras_ovf      in   one-cycle pulse: a push discarded the oldest entry
//   ras_unf      in   one-cycle pulse: ret with an empty stack
//   misalign     in   one-cycle pulse: unaligned redirect target rejected
//                     (present only when PC_ALIGN_CHECK_EN is defined)
// -----------------------------------------------------------------------------
interface pc_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             stall;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_target;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;
`ifdef PC_ALIGN_CHECK_EN
    logic             misalign;
`endif

    modport master (
        output stall, redir_valid, redir_target, call, ret,
`ifdef PC_ALIGN_CHECK_EN
        input  misalign,
`endif
        input  pc, pc_valid, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, redir_valid, redir_target, call, ret,
`ifdef PC_ALIGN_CHECK_EN
        output misalign,
`endif
        output pc, pc_valid, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Fetch-stage program counter. Generates the fetch address every cycle, steps
// by STEP, accepts branch/jump redirects and keeps a circular return-address
// stack (RAS) for call/return. All outputs are registered.
//
// Parameters:
//   WIDTH        PC width in bits
//   STEP         sequential increment, power of two (1 = word, 4 = byte addr)
//   RESET_VECTOR PC value held during and immediately after reset
//   RAS_DEPTH    number of RAS entries, 2..16
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    pc_unit_if.slave (control inputs, pc/status outputs)
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : unaligned redirect targets are rejected (pc holds, no push,
//               misalign pulses)
//   undefined : low log2(STEP) target bits are forced to zero, no misalign port
//
// Sequencing: while rst_n=0 the block is in its reset condition; the first
// edge after release (START) only raises pc_valid; every later edge (RUN)
// selects the next pc with priority ret > redirect > stall > step.
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_unit_if.slave  bus
);

    localparam int               PW         = $clog2(RAS_DEPTH);
    localparam int               CW         = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    localparam logic [PW-1:0]    LAST_IDX   = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]    FULL_CNT   = CW'(RAS_DEPTH);

    // The reset condition itself is the asserted rst_n; the state register
    // only distinguishes the start edge from normal running.
    typedef enum logic {
        ST_START,
        ST_RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;   // slot the next push writes
    logic [CW-1:0]    count_q, count_d;
    logic             ras_empty_q, ras_full_q;
    logic             ras_ovf_q, ras_ovf_d;
    logic             ras_unf_q, ras_unf_d;
`ifdef PC_ALIGN_CHECK_EN
    logic             misalign_q, misalign_d;
    logic             target_bad;
`endif

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic             push, pop;
    logic [PW-1:0]    top_idx, next_idx;
    logic [WIDTH-1:0] pc_inc, target_ld;

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        pc_inc   = pc_q + STEP_W;
        // Circular indices; RAS_DEPTH need not be a power of two.
        top_idx  = (wr_ptr_q == '0) ? LAST_IDX : wr_ptr_q - 1'b1;
        next_idx = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;

`ifdef PC_ALIGN_CHECK_EN
        target_ld  = bus.redir_target;
        target_bad = |(bus.redir_target & ALIGN_MASK);
        misalign_d = 1'b0;
`else
        target_ld  = bus.redir_target & ~ALIGN_MASK;
`endif

        pc_d      = pc_q;
        push      = 1'b0;
        pop       = 1'b0;
        ras_unf_d = 1'b0;

        if (state_q == ST_RUN) begin
            if (bus.ret) begin
                // ret masks both redir_valid and call.
                if (count_q != '0) begin
                    pc_d = ras_mem[top_idx];
                    pop  = 1'b1;
                end else begin
                    // Underflow still advances, even under stall.
                    pc_d      = pc_inc;
                    ras_unf_d = 1'b1;
                end
            end else if (bus.redir_valid) begin
`ifdef PC_ALIGN_CHECK_EN
                if (target_bad) begin
                    misalign_d = 1'b1;
                end else begin
                    pc_d = target_ld;
                    push = bus.call;
                end
`else
                pc_d = target_ld;
                push = bus.call;
`endif
            end else if (!bus.stall) begin
                pc_d = pc_inc;
            end
        end

        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ras_ovf_d = 1'b0;
        if (push) begin
            // On a full stack the write slot is the oldest entry, so
            // advancing the pointer overwrites it and the count stays put.
            wr_ptr_d = next_idx;
            if (count_q == FULL_CNT) begin
                ras_ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            wr_ptr_d = top_idx;
            count_d  = count_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RAS storage: contents are don't-care after reset (count gates reads)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wr_ptr_q] <= pc_inc;
        end
    end

    // ------------------------------------------------------------------
    // State machine and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_START;
            pc_q        <= RESET_VECTOR;
            pc_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
            ras_ovf_q   <= 1'b0;
            ras_unf_q   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_START: begin
                    // Control inputs ignored; pc stays at RESET_VECTOR.
                    pc_valid_q <= 1'b1;
                    state_q    <= ST_RUN;
                end
                ST_RUN: begin
                    pc_q        <= pc_d;
                    wr_ptr_q    <= wr_ptr_d;
                    count_q     <= count_d;
                    ras_empty_q <= (count_d == '0);
                    ras_full_q  <= (count_d == FULL_CNT);
                    ras_ovf_q   <= ras_ovf_d;
                    ras_unf_q   <= ras_unf_d;
`ifdef PC_ALIGN_CHECK_EN
                    misalign_q  <= misalign_d;
`endif
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = pc_valid_q;
    assign bus.ras_empty = ras_empty_q;
    assign bus.ras_full  = ras_full_q;
    assign bus.ras_ovf   = ras_ovf_q;
    assign bus.ras_unf   = ras_unf_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Scoreboard bench for pc_unit (WIDTH=32, STEP=4, RESET_VECTOR=0x100,
// RAS_DEPTH=4). The driver applies one stimulus per cycle at the falling edge,
// advances a queue-based reference model and pushes the expected post-edge
// outputs; a monitor pops one expectation after each rising edge and compares.
// Honours PC_ALIGN_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] STEP  = 32'd4;
    localparam logic [31:0] RV    = 32'h100;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
        logic        mis;
    } obs_t;

    logic clk;
    logic rst_n;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH        (32),
        .STEP         (4),
        .RESET_VECTOR (32'h100),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and counters
    obs_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: plain PC value, started flag and a queue as the stack
    logic [31:0] m_pc;
    bit          m_started;
    logic [31:0] m_ras[$];

    function automatic obs_t sample();
        obs_t a;
        a.pc    = bus.pc;
        a.valid = bus.pc_valid;
        a.empty = bus.ras_empty;
        a.full  = bus.ras_full;
        a.ovf   = bus.ras_ovf;
        a.unf   = bus.ras_unf;
`ifdef PC_ALIGN_CHECK_EN
        a.mis   = bus.misalign;
`else
        a.mis   = 1'b0;
`endif
        return a;
    endfunction

    task automatic compare(input string name, input obs_t a, input obs_t e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s #%0d: got pc=%h v=%b e=%b f=%b o=%b u=%b m=%b, want pc=%h v=%b e=%b f=%b o=%b u=%b m=%b",
                     name, n_cmp, a.pc, a.valid, a.empty, a.full, a.ovf, a.unf, a.mis,
                     e.pc, e.valid, e.empty, e.full, e.ovf, e.unf, e.mis);
        end else begin
            $display("%s #%0d ok: pc=%h v=%b e=%b f=%b o=%b u=%b m=%b",
                     name, n_cmp, a.pc, a.valid, a.empty, a.full, a.ovf, a.unf, a.mis);
        end
    endtask

    function automatic obs_t reset_obs();
        obs_t e;
        e       = '0;
        e.pc    = RV;
        e.empty = 1'b1;
        return e;
    endfunction

    // Monitor: one comparison per rising edge for which an expectation exists
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                compare("txn", sample(), exp_q.pop_front());
            end
        end
    end

    task automatic model_push(input logic [31:0] addr, inout obs_t e);
        m_ras.push_back(addr);
        if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            e.ovf = 1'b1;
        end
    endtask

    // Drive one cycle of stimulus (called at a falling edge) and predict
    task automatic step(input bit st, input bit rv, input logic [31:0] tgt,
                        input bit cl, input bit rt);
        obs_t e;
        bus.stall        = st;
        bus.redir_valid  = rv;
        bus.redir_target = tgt;
        bus.call         = cl;
        bus.ret          = rt;

        e = '0;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (rt) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = m_pc + STEP;
                e.unf = 1'b1;
            end
        end else if (rv) begin
`ifdef PC_ALIGN_CHECK_EN
            if ((tgt % STEP) != 0) begin
                e.mis = 1'b1;
            end else begin
                if (cl) model_push(m_pc + STEP, e);
                m_pc = tgt;
            end
`else
            if (cl) model_push(m_pc + STEP, e);
            m_pc = tgt - (tgt % STEP);
`endif
        end else if (!st) begin
            m_pc = m_pc + STEP;
        end
        e.pc    = m_pc;
        e.valid = 1'b1;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 32'h0, 0, 0);
    endtask

    // Assert reset asynchronously, check, hold for two edges, release at a
    // falling edge so the next step() lands on the start edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        compare("reset_now", sample(), reset_obs());
        m_pc      = RV;
        m_started = 1'b0;
        m_ras.delete();
        @(negedge clk);
        @(negedge clk);
        compare("reset_hold", sample(), reset_obs());
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        bit st, rv, cl, rt;

        rst_n            = 1'b1;
        bus.stall        = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_target = '0;
        bus.call         = 1'b0;
        bus.ret          = 1'b0;
        #2;
        do_reset();

        // Start edge then first step
        step(0, 1, 32'h800, 1, 0);   // ignored on start edge
        idle(1);
        // Stall holds, redirect overrides stall
        for (int k = 0; k < 3; k++) step(1, 0, 32'h0, 0, 0);
        step(1, 1, 32'h200, 0, 0);
        // Call / two sequential / return
        step(0, 1, 32'h300, 1, 0);
        idle(2);
        step(0, 0, 32'h0, 0, 1);
        // Nested calls with overflow, then returns with underflow
        step(0, 1, 32'h10, 0, 0);
        for (int k = 2; k <= 6; k++) step(0, 1, 32'(k * 16), 1, 0);
        for (int k = 0; k < 6; k++) step(k[0], 0, 32'h0, 0, 1);
        // Wrap-around
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        idle(1);
        // Unaligned call target, then return
        step(0, 1, 32'h200, 0, 0);
        step(0, 1, 32'h202, 1, 0);
        step(0, 0, 32'h0, 0, 1);
        // ret masks simultaneous redirect and call
        step(0, 1, 32'h400, 1, 1);
        step(1, 0, 32'h0, 0, 1);

        // Reset mid-run, then randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 250 || i == 480) do_reset();
            st  = ($urandom_range(0, 99) < 30);
            rt  = ($urandom_range(0, 99) < 15);
            rv  = ($urandom_range(0, 99) < 30);
            cl  = ($urandom_range(0, 99) < 55);
            tgt = $urandom_range(0, 4095) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 99) < 20) tgt = tgt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 99) < 5)  tgt = 32'hFFFF_FFFC;
            step(st, rv, tgt, cl, rt);
        end
        step(0, 0, 32'h0, 0, 0);

        // Drain: bounded wait for the monitor to consume the last expectation
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
